// File: rtl/gp_arbiter_pkg.sv
// Shared graphics-processor definitions: opcodes, coordinate widths, screen limits
// and the arbiter state encoding.
package gp_pkg;

  localparam int unsigned X_W     = 10;
  localparam int unsigned Y_W     = 9;
  localparam int unsigned COLOR_W = 12;

  localparam logic GP_FILL    = 1'b0;
  localparam logic GP_OUTLINE = 1'b1;

  localparam logic [X_W-1:0] SCREEN_X_MAX = 10'd639;
  localparam logic [Y_W-1:0] SCREEN_Y_MAX = 9'd479;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_DRAIN = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic               opcode;
    logic [X_W-1:0]     tl_x;
    logic [Y_W-1:0]     tl_y;
    logic [X_W-1:0]     br_x;
    logic [Y_W-1:0]     br_y;
    logic [COLOR_W-1:0] arg;
  } gp_cmd_t;

endpackage

// File: rtl/gp_arbiter_if.sv
// Painter-side request bundle plus graphics-processor command port.
// master = arbiter view, slave = painters/graphics-processor view.
interface gp_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  import gp_pkg::*;

  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ-1:0]         req_opcode;
  logic [NUM_REQ*X_W-1:0]     req_tl_x;
  logic [NUM_REQ*Y_W-1:0]     req_tl_y;
  logic [NUM_REQ*X_W-1:0]     req_br_x;
  logic [NUM_REQ*Y_W-1:0]     req_br_y;
  logic [NUM_REQ*COLOR_W-1:0] req_arg;
  logic [NUM_REQ-1:0]         grant;
  logic [NUM_REQ-1:0]         done;

  logic                       gp_finish;
  logic                       gp_en;
  logic                       gp_opcode;
  logic [X_W-1:0]             gp_tl_x;
  logic [Y_W-1:0]             gp_tl_y;
  logic [X_W-1:0]             gp_br_x;
  logic [Y_W-1:0]             gp_br_y;
  logic [COLOR_W-1:0]         gp_arg;
  logic                       busy;

  modport master (
    input  req, req_opcode, req_tl_x, req_tl_y, req_br_x, req_br_y, req_arg,
    input  gp_finish,
    output grant, done, gp_en, gp_opcode, gp_tl_x, gp_tl_y, gp_br_x, gp_br_y,
    output gp_arg, busy
  );

  modport slave (
    output req, req_opcode, req_tl_x, req_tl_y, req_br_x, req_br_y, req_arg,
    output gp_finish,
    input  grant, done, gp_en, gp_opcode, gp_tl_x, gp_tl_y, gp_br_x, gp_br_y,
    input  gp_arg, busy
  );

endinterface

// File: rtl/gp_arbiter_rr_pick.sv
// Combinational round-robin select: first set request scanning ptr, ptr+1, ... mod N.
module rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    int unsigned j;
    j      = 0;
    valid  = 1'b0;
    idx    = '0;
    onehot = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(ptr) + k) % N;
      if (!valid && req[IDX_W'(j)]) begin
        valid = 1'b1;
        idx   = IDX_W'(j);
      end
    end
    if (valid) onehot = N'(1) << idx;
  end

endmodule

// File: rtl/gp_arbiter.sv
// Round-robin arbiter sharing the graphics-processor command port between NUM_REQ painters.
// Optional watchdog on ISSUE enabled by defining GP_ARB_TIMEOUT_EN (adds timeout_err port).
module gp_arbiter
  import gp_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic          clk,
  input  logic          rst_n,
  gp_arbiter_if.master  bus
`ifdef GP_ARB_TIMEOUT_EN
  ,
  output logic          timeout_err
`endif
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   win_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] done_q;
  logic               gp_en_q;
  gp_cmd_t            cmd_q;

  logic               pick_valid;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               latch_cmd;
  logic               finish_cmd;
  logic               release_cmd;
  logic               timed_out;
  gp_cmd_t            cmd_a [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign cmd_a[i] = '{
      opcode: bus.req_opcode[i],
      tl_x:   bus.req_tl_x[i*X_W +: X_W],
      tl_y:   bus.req_tl_y[i*Y_W +: Y_W],
      br_x:   bus.req_br_x[i*X_W +: X_W],
      br_y:   bus.req_br_y[i*Y_W +: Y_W],
      arg:    bus.req_arg[i*COLOR_W +: COLOR_W]
    };
  end

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req    (bus.req),
    .ptr    (rr_ptr_q),
    .valid  (pick_valid),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    latch_cmd   = 1'b0;
    finish_cmd  = 1'b0;
    release_cmd = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        // A stuck-high finish from the previous command blocks new grants.
        if (pick_valid && !bus.gp_finish) begin
          latch_cmd = 1'b1;
          state_d   = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (bus.gp_finish || timed_out) begin
          finish_cmd = 1'b1;
          state_d    = ARB_DRAIN;
        end
      end
      ARB_DRAIN: begin
        if (!bus.gp_finish) begin
          release_cmd = 1'b1;
          state_d     = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      win_q    <= '0;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      gp_en_q  <= 1'b0;
      cmd_q    <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= '0;
      if (latch_cmd) begin
        win_q   <= pick_idx;
        grant_q <= pick_onehot;
        cmd_q   <= cmd_a[pick_idx];
        gp_en_q <= 1'b1;
      end
      if (finish_cmd) begin
        gp_en_q <= 1'b0;
        done_q  <= grant_q;
      end
      if (release_cmd) begin
        grant_q  <= '0;
        rr_ptr_q <= (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + IDX_W'(1);
      end
    end
  end

`ifdef GP_ARB_TIMEOUT_EN
  logic [31:0] to_cnt_q;

  // Fires on the last of TIMEOUT_CYCLES cycles in ISSUE, so gp_en stays high exactly that long.
  assign timed_out = (state_q == ARB_ISSUE) && (to_cnt_q == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt_q    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state_q != ARB_ISSUE) begin
        to_cnt_q <= '0;
      end else if (!timed_out) begin
        to_cnt_q <= to_cnt_q + 32'd1;
      end
      if (finish_cmd && !bus.gp_finish) timeout_err <= 1'b1;
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  assign bus.grant     = grant_q;
  assign bus.done      = done_q;
  assign bus.gp_en     = gp_en_q;
  assign bus.gp_opcode = cmd_q.opcode;
  assign bus.gp_tl_x   = cmd_q.tl_x;
  assign bus.gp_tl_y   = cmd_q.tl_y;
  assign bus.gp_br_x   = cmd_q.br_x;
  assign bus.gp_br_y   = cmd_q.br_y;
  assign bus.gp_arg    = cmd_q.arg;
  assign bus.busy      = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_gp_arbiter.sv
// Self-checking bench for gp_arbiter: directed cases plus randomized traffic against
// a transaction-level round-robin model. Define GP_ARB_TIMEOUT_EN to cover the watchdog.
module tb_gp_arbiter;
  import gp_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gp_arbiter_if #(.NUM_REQ(N)) bus ();
`ifdef GP_ARB_TIMEOUT_EN
  logic timeout_err;
`endif

  gp_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef GP_ARB_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  logic [N-1:0]       rq;
  logic [N-1:0]       op;
  logic [X_W-1:0]     f_tlx [N];
  logic [Y_W-1:0]     f_tly [N];
  logic [X_W-1:0]     f_brx [N];
  logic [Y_W-1:0]     f_bry [N];
  logic [COLOR_W-1:0] f_arg [N];
  logic               finish;

  assign bus.req        = rq;
  assign bus.req_opcode = op;
  assign bus.gp_finish  = finish;

  always_comb begin
    bus.req_tl_x = '0;
    bus.req_tl_y = '0;
    bus.req_br_x = '0;
    bus.req_br_y = '0;
    bus.req_arg  = '0;
    for (int i = 0; i < N; i++) begin
      bus.req_tl_x[i*X_W +: X_W]         = f_tlx[i];
      bus.req_tl_y[i*Y_W +: Y_W]         = f_tly[i];
      bus.req_br_x[i*X_W +: X_W]         = f_brx[i];
      bus.req_br_y[i*Y_W +: Y_W]         = f_bry[i];
      bus.req_arg[i*COLOR_W +: COLOR_W]  = f_arg[i];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: set of outstanding requests and the next requester to favour.
  logic [N-1:0] pending;
  int unsigned  m_ptr;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned model_pick();
    for (int unsigned k = 0; k < N; k++)
      if (pending[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return N;
  endfunction

  function automatic logic [50:0] cmd_of(input int unsigned i);
    return {op[i], f_tlx[i], f_tly[i], f_brx[i], f_bry[i], f_arg[i]};
  endfunction

  function automatic logic [50:0] cmd_obs();
    return {bus.gp_opcode, bus.gp_tl_x, bus.gp_tl_y, bus.gp_br_x, bus.gp_br_y, bus.gp_arg};
  endfunction

  task automatic randomize_fields(input int unsigned i);
    op[i]    = 1'($urandom_range(0, 1));
    f_tlx[i] = X_W'($urandom_range(0, 639));
    f_tly[i] = Y_W'($urandom_range(0, 479));
    f_brx[i] = X_W'($urandom_range(0, 639));
    f_bry[i] = Y_W'($urandom_range(0, 479));
    f_arg[i] = COLOR_W'($urandom);
  endtask

  task automatic add_random_reqs(input int unsigned w);
    for (int unsigned i = 0; i < N; i++) begin
      if (i != w && !rq[i] && $urandom_range(0, 1) == 1) begin
        randomize_fields(i);
        rq[i]      = 1'b1;
        pending[i] = 1'b1;
      end
    end
  endtask

  // One full command: grant edge, lat cycles of gp_en, finish held hold cycles, release.
  task automatic serve(input int unsigned lat, input int unsigned hold, input bit withdraw,
                       input bit scramble, input bit allow_add, output int unsigned w);
    logic [50:0]  exp_cmd;
    logic [N-1:0] w_oh;
    w          = model_pick();
    exp_cmd    = cmd_of(w);
    w_oh       = N'(1) << w;
    pending[w] = 1'b0;
    tick();
    check_eq("gp_en_rise", 64'(bus.gp_en), 64'd1);
    check_eq("grant", 64'(bus.grant), 64'(w_oh));
    check_eq("cmd_latch", 64'(cmd_obs()), 64'(exp_cmd));
    check_eq("busy_issue", 64'(bus.busy), 64'd1);
    if (withdraw) rq[w] = 1'b0;
    if (scramble) begin
      randomize_fields(w);
      f_tlx[w] = 10'd100;
    end
    for (int unsigned c = 1; c < lat; c++) begin
      if (allow_add && $urandom_range(0, 3) == 0) add_random_reqs(w);
      tick();
      check_eq("gp_en_hold", 64'(bus.gp_en), 64'd1);
      check_eq("cmd_stable", 64'(cmd_obs()), 64'(exp_cmd));
      check_eq("done_quiet", 64'(bus.done), 64'd0);
    end
    finish = 1'b1;
    tick();
    check_eq("gp_en_fall", 64'(bus.gp_en), 64'd0);
    check_eq("done_pulse", 64'(bus.done), 64'(w_oh));
    rq[w] = 1'b0;
    for (int unsigned c = 0; c < hold; c++) begin
      tick();
      check_eq("done_clear", 64'(bus.done), 64'd0);
      check_eq("grant_drain", 64'(bus.grant), 64'(w_oh));
      check_eq("cmd_drain", 64'(cmd_obs()), 64'(exp_cmd));
    end
    finish = 1'b0;
    tick();
    check_eq("grant_release", 64'(bus.grant), 64'd0);
    check_eq("busy_idle", 64'(bus.busy), 64'd0);
    m_ptr = (w + 1) % N;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_gp_en"}, 64'(bus.gp_en), 64'd0);
    check_eq({tag, "_grant"}, 64'(bus.grant), 64'd0);
    check_eq({tag, "_done"}, 64'(bus.done), 64'd0);
    check_eq({tag, "_busy"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int unsigned w;
    rq      = '0;
    op      = '0;
    finish  = 1'b0;
    pending = '0;
    m_ptr   = 0;
    for (int unsigned i = 0; i < N; i++) randomize_fields(i);

    rst_n = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    check_eq("reset_cmd", 64'(cmd_obs()), 64'd0);
`ifdef GP_ARB_TIMEOUT_EN
    check_eq("reset_timeout_err", 64'(timeout_err), 64'd0);
`endif
    rst_n = 1'b1;
    repeat (2) tick();
    check_all_zero("idle_no_req");

    // Single full-screen fill from requester 0.
    op[0] = GP_FILL;
    f_tlx[0] = '0; f_tly[0] = '0;
    f_brx[0] = SCREEN_X_MAX; f_bry[0] = SCREEN_Y_MAX; f_arg[0] = 12'hFFF;
    rq[0] = 1'b1; pending[0] = 1'b1;
    serve(5, 1, 1'b0, 1'b0, 1'b0, w);

    // Finish stuck high in IDLE blocks the grant.
    randomize_fields(1);
    rq[1] = 1'b1; pending[1] = 1'b1;
    finish = 1'b1;
    repeat (3) begin
      tick();
      check_eq("stuck_finish_no_grant", 64'(bus.gp_en), 64'd0);
      check_eq("stuck_finish_idle", 64'(bus.busy), 64'd0);
    end
    finish = 1'b0;
    serve(2, 1, 1'b0, 1'b0, 1'b0, w);

    // Contention with pointer at 0; each served requester reasserts immediately.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    m_ptr = 0;
    rq = 4'b1011; pending = 4'b1011;
    for (int unsigned i = 0; i < N; i++) randomize_fields(i);
    for (int unsigned t = 0; t < 6; t++) begin
      serve(2 + t % 3, 1, 1'b0, (t == 1), 1'b0, w);
      rq[w] = 1'b1; pending[w] = 1'b1;
    end
    rst_n = 1'b0; tick(); rst_n = 1'b1;

    // Withdraw requester 2 right after its grant.
    m_ptr = 0;
    rq = 4'b0100; pending = 4'b0100;
    serve(3, 2, 1'b1, 1'b0, 1'b0, w);
    repeat (2) begin
      tick();
      check_eq("no_regrant_after_withdraw", 64'(bus.gp_en), 64'd0);
    end

    // Reset while a command is in ISSUE.
    rq = 4'b0011; pending = 4'b0011;
    tick();
    check_eq("pre_reset_gp_en", 64'(bus.gp_en), 64'd1);
    rst_n = 1'b0;
    tick();
    check_all_zero("mid_reset");
    rst_n = 1'b1;
    m_ptr = 0;
    rq = 4'b0100; pending = 4'b0100;
    serve(3, 1, 1'b0, 1'b0, 1'b0, w);

    // Randomized traffic.
    for (int unsigned it = 0; it < 150; it++) begin
      if (pending == '0) begin
        if ($urandom_range(0, 4) == 0) begin
          tick();
          check_eq("idle_gap", 64'(bus.gp_en), 64'd0);
        end
        while (pending == '0) add_random_reqs(N);
      end
      serve($urandom_range(1, 6), $urandom_range(1, 3), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 2) == 0), 1'b1, w);
    end
    while (pending != '0) serve(1, 1, 1'b0, 1'b0, 1'b0, w);

`ifdef GP_ARB_TIMEOUT_EN
    begin
      logic [N-1:0] t_oh;
      randomize_fields(3);
      rq[3] = 1'b1; pending[3] = 1'b1;
      w = model_pick();
      t_oh = N'(1) << w;
      pending[w] = 1'b0;
      tick();
      check_eq("to_gp_en_rise", 64'(bus.gp_en), 64'd1);
      for (int unsigned c = 1; c < TO; c++) begin
        tick();
        check_eq("to_gp_en_hold", 64'(bus.gp_en), 64'd1);
      end
      tick();
      check_eq("to_gp_en_fall", 64'(bus.gp_en), 64'd0);
      check_eq("to_done_pulse", 64'(bus.done), 64'(t_oh));
      check_eq("to_err_set", 64'(timeout_err), 64'd1);
      rq[w] = 1'b0;
      tick();
      check_eq("to_done_clear", 64'(bus.done), 64'd0);
      check_eq("to_grant_release", 64'(bus.grant), 64'd0);
      m_ptr = (w + 1) % N;
      rq[0] = 1'b1; pending[0] = 1'b1;
      serve(2, 1, 1'b0, 1'b0, 1'b0, w);
      check_eq("to_err_sticky", 64'(timeout_err), 64'd1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
